// File: rtl/lsu_controller.sv
// Load/store sequencer: one core access at a time onto a req/ready memory bus, with lane steering and timeout.
// Latency: >= 3 cycles per access (request, >= 1 wait, done); faulting accesses are answered in the request cycle.
// Backpressure: core_stall holds the core until mem_ready or the timeout ends the wait.
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wd,
  output logic [31:0] core_rd,
  output logic        core_stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_UBYTE = 3'd4;
  localparam logic [2:0] SZ_UHALF = 3'd5;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Access attributes needed after the request cycle to steer the load data
  typedef struct packed {
    logic [2:0] size;
    logic [1:0] off;
  } acc_t;

  state_t               state;
  state_t               state_nxt;
  acc_t                 acc_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic        size_legal;
  logic        addr_aligned;
  logic        fault;
  logic        accept;
  logic        timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // ------------------------------------------------------------------
  // Request qualification
  // ------------------------------------------------------------------
  always_comb begin
    size_legal   = 1'b1;
    addr_aligned = 1'b1;
    case (core_size)
      SZ_BYTE, SZ_UBYTE: addr_aligned = 1'b1;
      SZ_HALF, SZ_UHALF: addr_aligned = ~core_addr[0];
      SZ_WORD:           addr_aligned = (core_addr[1:0] == 2'b00);
      default:           size_legal   = 1'b0;
    endcase
  end

  assign fault   = core_req & ~(size_legal & addr_aligned);
  assign accept  = core_req & ~fault;
  assign timeout = (state == ST_WAIT) & ~mem_ready & (cnt == CNT_LAST);

  // ------------------------------------------------------------------
  // Store lane steering; loads always fetch the full word
  // ------------------------------------------------------------------
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = core_wd;
    case (core_size)
      SZ_BYTE, SZ_UBYTE: begin
        be_nxt    = 4'b0001 << core_addr[1:0];
        wdata_nxt = {4{core_wd[7:0]}};
      end
      SZ_HALF, SZ_UHALF: begin
        be_nxt    = core_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{core_wd[15:0]}};
      end
      default: ;
    endcase
    if (!core_we) begin
      be_nxt = 4'b1111;
    end
  end

  // ------------------------------------------------------------------
  // Load data extraction and extension
  // ------------------------------------------------------------------
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (acc_q.off)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: ;
    endcase
    rd_half = acc_q.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext = mem_rdata;
    case (acc_q.size)
      SZ_BYTE:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      SZ_UBYTE: load_ext = {24'd0, rd_byte};
      SZ_HALF:  load_ext = {{16{rd_half[15]}}, rd_half};
      SZ_UHALF: load_ext = {16'd0, rd_half};
      default:  load_ext = mem_rdata;
    endcase
  end

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_stall = 1'b0;
    misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        misaligned = fault;
        core_stall = accept;
        if (accept) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        core_stall = 1'b1;
        if (mem_ready || timeout) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Bus request, captured access and result registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      acc_q     <= '0;
      cnt       <= '0;
      core_rd   <= 32'd0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_req    <= 1'b1;
            mem_we     <= core_we;
            mem_be     <= be_nxt;
            mem_addr   <= {core_addr[31:2], 2'b00};
            mem_wdata  <= wdata_nxt;
            acc_q.size <= core_size;
            acc_q.off  <= core_addr[1:0];
            cnt        <= '0;
          end
        end
        ST_WAIT: begin
          // mem_ready takes priority over the terminal count
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              core_rd <= load_ext;
            end
          end else if (timeout) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            core_rd   <= 32'd0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          bus_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: directed cases with literal expectations, then randomized traffic
// scored every cycle against a transaction-level model of the access rules.
module tb_lsu_controller;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  lsu_controller #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_size  (core_size),
    .core_addr  (core_addr),
    .core_wd    (core_wd),
    .core_rd    (core_rd),
    .core_stall (core_stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs for the current cycle
  logic        e_on = 1'b0;
  logic        e_stall, e_mis, e_req, e_berr, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] e_rd = 32'd0;

  // Running observations of the bus, for the literal checks
  int          obs_req_cycles   = 0;
  int          obs_stall_cycles = 0;
  int          obs_mis          = 0;
  int          obs_berr         = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_fault(input logic [2:0] sz, input logic [31:0] a);
    int unsigned nb;
    if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    nb = 1 << sz[1:0];
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] sz, input logic [31:0] a);
    int unsigned nb;
    if (!we) return 4'hF;
    nb = 1 << sz[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] wd);
    int unsigned nb;
    logic [31:0] r;
    nb = 1 << sz[1:0];
    r  = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] rd);
    int unsigned nb;
    logic [31:0] v, mask;
    nb = 1 << sz[1:0];
    if (nb == 4) return rd;
    mask = (32'd1 << (8*nb)) - 32'd1;
    v    = (rd >> (8*off)) & mask;
    if (!sz[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (e_on) begin
        chk("core_stall", 32'(core_stall), 32'(e_stall));
        chk("misaligned", 32'(misaligned), 32'(e_mis));
        chk("bus_error",  32'(bus_error),  32'(e_berr));
        chk("mem_req",    32'(mem_req),    32'(e_req));
        chk("core_rd",    core_rd,         e_rd);
        if (e_req) begin
          chk("mem_addr", mem_addr,        e_addr);
          chk("mem_be",   32'(mem_be),     32'(e_be));
          chk("mem_we",   32'(mem_we),     32'(e_we));
          if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
      end
      if (mem_req === 1'b1) begin
        obs_req_cycles++;
        obs_addr  = mem_addr;
        obs_be    = mem_be;
        obs_we    = mem_we;
        obs_wdata = mem_wdata;
      end
      if (core_stall === 1'b1) obs_stall_cycles++;
      if (misaligned === 1'b1) obs_mis++;
      if (bus_error === 1'b1)  obs_berr++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_garbage();
    core_req  = 1'($urandom);
    core_we   = 1'($urandom);
    core_size = 3'($urandom);
    core_addr = $urandom;
    core_wd   = $urandom;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  task automatic set_idle();
    set_garbage();
    core_req = 1'b0;
    e_stall  = 1'b0;
    e_mis    = 1'b0;
    e_req    = 1'b0;
    e_berr   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      step();
    end
    set_idle();
  endtask

  // delay = WAIT-cycle index carrying mem_ready; delay >= T means the bus never answers
  task automatic run_txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    bit flt;
    bit tmo;
    int nwait;
    flt   = is_fault(sz, a);
    tmo   = (delay >= T);
    nwait = tmo ? T : delay + 1;
    set_idle();
    core_req  = 1'b1;
    core_we   = we;
    core_size = sz;
    core_addr = a;
    core_wd   = wd;
    e_stall   = !flt;
    e_mis     = flt;
    step();
    if (!flt) begin
      e_stall = 1'b1;
      e_mis   = 1'b0;
      e_req   = 1'b1;
      e_we    = we;
      e_addr  = {a[31:2], 2'b00};
      e_be    = model_be(we, sz, a);
      e_wdata = model_wdata(sz, wd);
      for (int k = 0; k < nwait; k++) begin
        set_garbage();
        mem_ready = 1'(!tmo && (k == delay));
        mem_rdata = mem_ready ? rdata : $urandom;
        step();
      end
      set_garbage();
      e_req   = 1'b0;
      e_stall = 1'b0;
      e_berr  = tmo;
      if (tmo) e_rd = 32'd0;
      else if (!we) e_rd = model_load(sz, a[1:0], rdata);
      step();
    end
    set_idle();
  endtask

  initial begin
    int r0, s0, m0, b0;
    rst_n = 1'b0;
    set_idle();
    step();
    step();
    chk("rst_mem_req",   32'(mem_req),    32'd0);
    chk("rst_mem_we",    32'(mem_we),     32'd0);
    chk("rst_mem_be",    32'(mem_be),     32'd0);
    chk("rst_mem_addr",  mem_addr,        32'd0);
    chk("rst_mem_wdata", mem_wdata,       32'd0);
    chk("rst_core_rd",   core_rd,         32'd0);
    chk("rst_bus_error", 32'(bus_error),  32'd0);
    chk("rst_misalign",  32'(misaligned), 32'd0);
    chk("rst_stall",     32'(core_stall), 32'd0);
    rst_n = 1'b1;
    e_rd  = 32'd0;
    e_on  = 1'b1;
    idle(2);

    // SW, ready on the second WAIT cycle
    r0 = obs_req_cycles; s0 = obs_stall_cycles;
    run_txn(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 1, $urandom);
    chk("sw_req_cycles",   32'(obs_req_cycles - r0),   32'd2);
    chk("sw_stall_cycles", 32'(obs_stall_cycles - s0), 32'd3);
    chk("sw_addr",  obs_addr,       32'h0000_0104);
    chk("sw_be",    32'(obs_be),    32'hF);
    chk("sw_we",    32'(obs_we),    32'd1);
    chk("sw_wdata", obs_wdata,      32'hDEADBEEF);
    idle(1);

    // LB / LHU / LH extraction
    run_txn(1'b0, 3'd0, 32'h203, 32'h0, 0, 32'h80112233);
    chk("lb_addr", obs_addr, 32'h0000_0200);
    chk("lb_rd",   core_rd,  32'hFFFFFF80);
    run_txn(1'b0, 3'd5, 32'h206, 32'h0, 2, 32'h9ABC1234);
    chk("lhu_rd",  core_rd,  32'h00009ABC);
    run_txn(1'b0, 3'd1, 32'h206, 32'h0, 0, 32'h9ABC1234);
    chk("lh_rd",   core_rd,  32'hFFFF9ABC);

    // Faults: misaligned half, illegal size
    r0 = obs_req_cycles; m0 = obs_mis;
    run_txn(1'b1, 3'd1, 32'h301, 32'h1234, 0, 32'h0);
    run_txn(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h0);
    chk("fault_mis_count", 32'(obs_mis - m0),        32'd2);
    chk("fault_no_req",    32'(obs_req_cycles - r0), 32'd0);
    idle(1);

    // SB with no answer: timeout
    r0 = obs_req_cycles; b0 = obs_berr;
    run_txn(1'b1, 3'd0, 32'h002, 32'h000000A5, T, 32'h0);
    chk("tmo_req_cycles", 32'(obs_req_cycles - r0), 32'd16);
    chk("tmo_be",         32'(obs_be),              32'b0100);
    chk("tmo_wdata",      obs_wdata,                32'hA5A5A5A5);
    chk("tmo_berr",       32'(obs_berr - b0),       32'd1);

    // mem_ready on the terminal count wins
    r0 = obs_req_cycles; b0 = obs_berr;
    run_txn(1'b0, 3'd2, 32'h400, 32'h0, T - 1, 32'h0BAD_F00D);
    chk("tc_req_cycles", 32'(obs_req_cycles - r0), 32'd16);
    chk("tc_no_berr",    32'(obs_berr - b0),       32'd0);
    chk("tc_rd",         core_rd,                  32'h0BAD_F00D);

    // Reset during WAIT
    e_on = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
    step();
    set_garbage();
    mem_ready = 1'b0;
    step();
    chk("rstw_req_before", 32'(mem_req), 32'd1);
    core_req  = 1'b0;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_req_drop", 32'(mem_req), 32'd0);
    step();
    rst_n = 1'b1;
    e_rd  = 32'd0;
    set_idle();
    e_on  = 1'b1;
    idle(1);
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 2, 32'h13572468);
    chk("rstw_lw_rd", core_rd, 32'h13572468);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int          d;
      int unsigned nb;
      if ($urandom_range(0, 9) != 0) begin
        case ($urandom_range(0, 4))
          0: sz = 3'd0;
          1: sz = 3'd1;
          2: sz = 3'd2;
          3: sz = 3'd4;
          default: sz = 3'd5;
        endcase
      end else begin
        sz = 3'($urandom);
      end
      a  = $urandom;
      nb = 1 << sz[1:0];
      if ($urandom_range(0, 2) != 0) a = a & ~(nb - 1);
      d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, T + 2);
      run_txn(1'($urandom), sz, a, $urandom, d, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Load/store sequencing unit between the single-cycle core and the external data memory.
- Takes the decoder's memory controls (memory_require, memory_write_enable, memory_size) plus the ALU-computed address and the store data.
- Runs a request/ready transaction on the memory bus, stalling the core until that transaction completes.
- Handles byte-enable generation, store-data lane replication, load-data extraction with sign/zero extension, alignment checks, and a bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without mem_ready before the access is aborted; legal range 1..255.
CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
core_req  in  1  memory access requested (decoder memory_require).
core_we  in  1  1 = store, 0 = load (decoder memory_write_enable).
core_size  in  3  access size from defines.v: DATA_SIZE_BYTE=0, HALF_WORD=1, WORD=2, U_BYTE=4, U_HALF_WORD=5.
core_addr  in  32  byte address (ALU result).
core_wd  in  32  store data (register-file RD2).
core_rd  out  32  extended load result; feeds writeback.
core_stall  out  1  hold PC and register-file write enable.
misaligned  out  1  one-cycle access fault (misaligned address or illegal size).
bus_error  out  1  one-cycle timeout fault.
mem_req  out  1  bus request.
mem_we  out  1  bus write.
mem_be  out  4  byte enables.
mem_addr  out  32  word address, {addr[31:2], 2'b00}.
mem_wdata  out  32  lane-replicated store data.
mem_rdata  in  32  read data; valid when mem_ready=1.
mem_ready  in  1  transaction complete.

Behaviour:
Clock and reset:
- One clock (clk); reset rst_n is asynchronous and active-low.
- On reset: state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_rd and the counter all 0; misaligned=0; bus_error=0.
- Reset asserted mid-transaction drops mem_req immediately, without waiting for a clock edge.

FSM states: IDLE, WAIT, DONE.

Fault check (combinational):
- fault = core_req & (illegal size (3, 6, 7) | HALF/U_HALF with addr[0]=1 | WORD with addr[1:0]!=0).

IDLE:
- core_req=1 and fault=1: misaligned=1 combinationally, core_stall=0, no bus activity, stay in IDLE.
- core_req=1 and fault=0: core_stall=1. On the edge, register mem_addr, mem_we, mem_be, mem_wdata, the size and addr[1:0]; set mem_req=1; clear the counter; go to WAIT.

WAIT:
- core_stall=1; all mem_* outputs held stable.
- mem_ready=1: register the extracted load data into core_rd (stores leave core_rd unchanged); mem_req=0; go to DONE.
- Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without mem_ready: mem_req=0, bus_error=1 (registered, high for the DONE cycle), core_rd=0, go to DONE.
- mem_ready in the same cycle as the timeout terminal count: mem_ready wins, no bus_error.
- core_req changing during WAIT is ignored.

DONE:
- core_stall=0 for exactly one cycle, so the core retires the instruction on this edge.
- bus_error clears on exit; next state is IDLE.
- Latency: minimum 3 cycles per access (IDLE→WAIT→DONE with mem_ready in the first WAIT cycle).

core_stall is combinational: core_req & ~fault in IDLE; 1 in WAIT; 0 in DONE.

Stores:
- BYTE: be=4'b0001<<addr[1:0]; wdata = 4 copies of wd[7:0].
- HALF: be=4'b0011 or 4'b1100 (selected by addr[1]); wdata = 2 copies of wd[15:0].
- WORD: be=4'b1111; wdata = wd.

Loads:
- mem_be=4'b1111; mem_we=0.
- BYTE/U_BYTE select rdata byte addr[1:0]; HALF/U_HALF select the half addr[1].
- BYTE/HALF sign-extend; U_ variants zero-extend.
- WORD passes rdata through.

Test Plan:
- SW, addr=0x104, wd=0xDEADBEEF, mem_ready on the 2nd WAIT cycle → mem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1; core_stall high 3 cycles, low in DONE.
- LB, addr=0x203, rdata=0x80112233 → mem_addr=0x200, core_rd=0xFFFFFF80.
- LHU, addr=0x206, rdata=0x9ABC1234 → core_rd=0x00009ABC; LH with the same inputs → core_rd=0xFFFF9ABC.
- SH, addr=0x301 → misaligned=1 the same cycle, core_stall=0, mem_req never asserted; core_size=3 with aligned addr → same response.
- SB, addr=0x002, wd=0x000000A5, mem_ready held 0, TIMEOUT_CYCLES=16 → mem_req high 16 cycles with be=0100 and wdata=0xA5A5A5A5; then bus_error=1 for one cycle, core_stall=0, return to IDLE.
- rst_n pulled low during WAIT → mem_req=0 before the next edge; after release, state=IDLE; a new LW completes normally.
